// File: rtl/uart_alu_host.sv
`timescale 1ns/1ps
// Host-side sequencer for the UART-ALU link: sends operand A, operand B and op code, then captures the result byte.
// SEND_A follows i_start by one cycle; each byte waits for the uart tx done tick; response wait is bounded by TIMEOUT_CYCLES.
module uart_alu_host #(
  parameter int NB_DATA        = 8,
  parameter int NB_CODE        = 6,
  parameter int NB_TIMEOUT     = 22,
  parameter int TIMEOUT_CYCLES = 3200000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_CODE-1:0] i_op_code,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_tx_done_tick,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic [NB_DATA-1:0] o_result
);

  typedef enum logic [3:0] {
    IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES, DONE
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t              state, state_next;
  logic [NB_DATA-1:0]  data_a_q, data_b_q, op_q;
  logic [NB_TIMEOUT-1:0] cnt;
  logic                cnt_last;
  logic [NB_DATA-1:0]  op_ext;

  logic                tx_start_nxt, busy_nxt, done_nxt, timeout_nxt;
  logic [NB_DATA-1:0]  tx_data_nxt, result_nxt;

  assign cnt_last = (cnt == CNT_LAST);
  assign op_ext   = {{(NB_DATA-NB_CODE){1'b0}}, i_op_code};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (i_start) state_next = SEND_A;
      SEND_A:   state_next = WAIT_A;
      WAIT_A:   if (i_tx_done_tick) state_next = SEND_B;
      SEND_B:   state_next = WAIT_B;
      WAIT_B:   if (i_tx_done_tick) state_next = SEND_OP;
      SEND_OP:  state_next = WAIT_OP;
      WAIT_OP:  if (i_tx_done_tick) state_next = WAIT_RES;
      // a result arriving on the terminal count takes priority over the timeout
      WAIT_RES: if (i_rx_done_tick) state_next = DONE;
                else if (cnt_last)  state_next = IDLE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state they describe.
  always_comb begin
    tx_start_nxt = 1'b0;
    tx_data_nxt  = o_tx_data;
    busy_nxt     = (state_next != IDLE);
    done_nxt     = (state_next == DONE);
    timeout_nxt  = (state == WAIT_RES) && !i_rx_done_tick && cnt_last;
    result_nxt   = o_result;
    case (state_next)
      SEND_A:  begin tx_start_nxt = 1'b1; tx_data_nxt = i_data_a; end
      SEND_B:  begin tx_start_nxt = 1'b1; tx_data_nxt = data_b_q; end
      SEND_OP: begin tx_start_nxt = 1'b1; tx_data_nxt = op_q;     end
      default: ;
    endcase
    if ((state == WAIT_RES) && i_rx_done_tick) result_nxt = i_rx_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      cnt        <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_timeout  <= 1'b0;
      o_result   <= '0;
    end else begin
      if ((state == IDLE) && i_start) begin
        data_a_q <= i_data_a;
        data_b_q <= i_data_b;
        op_q     <= op_ext;
      end
      cnt        <= (state == WAIT_RES) ? cnt + NB_TIMEOUT'(1) : '0;
      o_tx_start <= tx_start_nxt;
      o_tx_data  <= tx_data_nxt;
      o_busy     <= busy_nxt;
      o_done     <= done_nxt;
      o_timeout  <= timeout_nxt;
      o_result   <= result_nxt;
    end
  end

endmodule

// File: tb/tb_uart_alu_host.sv
`timescale 1ns/1ps
// Scoreboarded bench for uart_alu_host: a scripted uart/ALU responder drives the link, a monitor checks bytes and results.
module tb_uart_alu_host;

  localparam int TO = 100;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_data_a = '0, i_data_b = '0;
  logic [5:0] i_op_code = '0;
  logic       i_tx_done_tick = 1'b0, i_rx_done_tick = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       o_tx_start, o_busy, o_done, o_timeout;
  logic [7:0] o_tx_data, o_result;

  uart_alu_host #(.NB_DATA(8), .NB_CODE(6), .NB_TIMEOUT(22), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_op_code(i_op_code),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done_tick(i_tx_done_tick),
    .i_rx_done_tick(i_rx_done_tick), .i_rx_data(i_rx_data),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_tx[$];
  bit         exp_kind[$];   // 0 = result captured, 1 = timeout
  logic [7:0] exp_val[$];
  logic [7:0] last_result = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU behaviour the far end would compute.
  function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: every tx strobe and every done/timeout pulse is matched against the queued expectations.
  initial begin : monitor
    bit prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        prev_start = 1'b0;
      end else begin
        if (o_tx_start) begin
          check("tx_start_single_cycle", prev_start, 0);
          if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got byte 0x%0h, expected no transmission", o_tx_data);
          end else begin
            check("tx_byte", o_tx_data, exp_tx.pop_front());
          end
        end
        prev_start = o_tx_start;
        if (o_done || o_timeout) begin
          if (exp_kind.size() == 0) begin
            checks++; errors++;
            $display("FAIL event_unexpected: got done=%0b timeout=%0b, expected none", o_done, o_timeout);
          end else begin
            bit k;
            logic [7:0] v;
            k = exp_kind.pop_front();
            v = exp_val.pop_front();
            check("event_kind", {o_timeout, o_done}, k ? 2'b10 : 2'b01);
            check("result", o_result, v);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_tx_start) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  // Present a transaction in an IDLE cycle; returns in the SEND_A cycle.
  task automatic start_txn(logic [7:0] a, logic [7:0] b, logic [5:0] op, bit hold);
    i_data_a = a; i_data_b = b; i_op_code = op; i_start = 1'b1;
    exp_tx.push_back(a); exp_tx.push_back(b); exp_tx.push_back({2'b00, op});
    tick();
    if (!hold) i_start = 1'b0;
    check("send_a_latency", o_tx_start, 1);
  endtask

  // Act as the uart transmitter for the three bytes; returns in the first WAIT_RES cycle.
  task automatic serve_tx(int dly, bit stray);
    bit ok;
    logic s_start;
    for (int k = 0; k < 3; k++) begin
      wait_tx(ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL tx_wait: got no o_tx_start for byte %0d, expected one within 50 cycles", k);
        return;
      end
      tick();
      check("busy_in_wait", o_busy, 1);
      if (stray && k == 1) begin
        s_start = i_start;
        i_start = 1'b1; i_data_a = 8'hAA; i_data_b = 8'h55; i_op_code = 6'h22;
        i_rx_done_tick = 1'b1; i_rx_data = 8'hFF;
        tick();
        i_start = s_start; i_rx_done_tick = 1'b0;
      end
      repeat (dly) tick();
      i_tx_done_tick = 1'b1;
      tick();
      i_tx_done_tick = 1'b0;
    end
  endtask

  // Answer d cycles into WAIT_RES; returns in the IDLE cycle after DONE.
  task automatic respond(int d, logic [7:0] val);
    exp_kind.push_back(1'b0); exp_val.push_back(val); last_result = val;
    repeat (d) tick();
    i_rx_done_tick = 1'b1; i_rx_data = val;
    tick();
    i_rx_done_tick = 1'b0; i_rx_data = 8'($urandom);
    check("done_latency", o_done, 1);
    tick();
    check("busy_after_done", o_busy, 0);
  endtask

  task automatic no_respond();
    int n;
    exp_kind.push_back(1'b1); exp_val.push_back(last_result);
    n = 0;
    for (int i = 1; i <= 2 * TO; i++) begin
      tick();
      if (o_timeout) begin n = i; break; end
    end
    check("timeout_cycles", n, TO);
    check("busy_after_timeout", o_busy, 0);
    tick();
  endtask

  initial begin : stim
    logic [5:0] ops[8];
    logic [7:0] a, b;
    logic [5:0] op;
    int mode;
    bit ok;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_result", o_result, 0);
    i_reset = 1'b0;
    tick(); tick();

    // Nominal ADD, then the same with stray start/rx during WAIT_B
    start_txn(8'h03, 8'h08, 6'h20, 1'b0);
    serve_tx(0, 1'b0);
    respond(3, alu_ref(8'h03, 8'h08, 6'h20));
    start_txn(8'h03, 8'h08, 6'h20, 1'b0);
    serve_tx(2, 1'b1);
    respond(5, alu_ref(8'h03, 8'h08, 6'h20));

    // Timeout keeps previous result, then rx exactly on the terminal count
    start_txn(8'h21, 8'h12, 6'h26, 1'b0);
    serve_tx(1, 1'b0);
    no_respond();
    start_txn(8'h21, 8'h12, 6'h26, 1'b0);
    serve_tx(0, 1'b0);
    respond(TO - 1, 8'h5A);

    // Asynchronous reset in WAIT_A
    start_txn(8'h33, 8'h44, 6'h20, 1'b0);
    wait_tx(ok);
    tick();
    check("busy_before_reset", o_busy, 1);
    #2 i_reset = 1'b1;
    #1;
    check("async_rst_outputs", {o_tx_start, o_tx_data, o_busy, o_done, o_timeout, o_result}, 0);
    exp_tx.delete(); exp_kind.delete(); exp_val.delete(); last_result = '0;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    tick();
    start_txn(8'h10, 8'h01, 6'h22, 1'b0);
    serve_tx(1, 1'b0);
    respond(2, alu_ref(8'h10, 8'h01, 6'h22));

    // Back-to-back with i_start held high throughout
    start_txn(8'h03, 8'h08, 6'h20, 1'b1);
    serve_tx(0, 1'b0);
    i_data_a = 8'h0F; i_data_b = 8'h3C; i_op_code = 6'h24;
    respond(1, alu_ref(8'h03, 8'h08, 6'h20));
    exp_tx.push_back(8'h0F); exp_tx.push_back(8'h3C); exp_tx.push_back(8'h24);
    tick();
    check("b2b_send_a_gap", o_tx_start, 1);
    i_start = 1'b0;
    serve_tx(0, 1'b0);
    respond(4, alu_ref(8'h0F, 8'h3C, 6'h24));

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = ops[$urandom_range(0, 7)];
      mode = $urandom_range(0, 9);
      repeat ($urandom_range(0, 3)) tick();
      start_txn(a, b, op, 1'b0);
      i_data_a = 8'($urandom); i_data_b = 8'($urandom); i_op_code = 6'($urandom);
      serve_tx($urandom_range(0, 3), mode == 2);
      if (mode == 0)      no_respond();
      else if (mode == 1) respond(TO - 1, alu_ref(a, b, op));
      else                respond($urandom_range(0, 40), alu_ref(a, b, op));
    end

    repeat (5) tick();
    check("pending_tx", exp_tx.size(), 0);
    check("pending_events", exp_kind.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
